// File: rtl/leve1_rd_target_if.sv
// AXI read-channel bundle shared by read targets and their initiators.
interface AXI;
  logic [31:0]  ARADDR;
  logic         ARVALID;
  logic         ARREADY;
  logic [127:0] RDATA;
  logic [1:0]   RRESP;
  logic         RVALID;
  logic         RREADY;

  modport r_targ (input ARADDR, ARVALID, RREADY, output ARREADY, RDATA, RRESP, RVALID);
  modport r_init (output ARADDR, ARVALID, RREADY, input ARREADY, RDATA, RRESP, RVALID);
endinterface

// File: rtl/leve1_rd_target.sv
// Read-only AXI read target over a constant memory image; requests are queued
// (index + decode error) and the response word is rebuilt from the queue head.
module leve1_rd_target #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_LOG2  = 10,
  parameter int          OUTSTANDING = 4
) (
  input logic CLK,
  input logic RST,
  AXI.r_targ  RIT
);
  localparam int NUM_LANES = 4;
  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'd16 << DEPTH_LOG2);

  typedef struct packed {
    logic                  err;
    logic [DEPTH_LOG2-1:0] idx;
  } req_t;

  req_t                        q [OUTSTANDING];
  req_t                        new_req, head;
  logic [PW-1:0]               wptr, rptr;
  logic [CW-1:0]               cnt;
  logic                        full, empty, acc, ret;
  logic [32:0]                 addr33;
  logic [31:0]                 word_base;
  logic [NUM_LANES-1:0][31:0]  lanes;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (cnt == CW'(OUTSTANDING));
  assign empty = (cnt == '0);

  // Reset gating keeps ARREADY low while RST is held without waiting for an edge.
  assign RIT.ARREADY = !RST && !full;
  assign RIT.RVALID  = !empty;
  assign acc = RIT.ARVALID && RIT.ARREADY;
  assign ret = RIT.RVALID && RIT.RREADY;

  assign addr33      = {1'b0, RIT.ARADDR};
  assign new_req.err = !((addr33 >= {1'b0, BASE_ADDR}) && (addr33 < LIMIT));
  assign new_req.idx = DEPTH_LOG2'((RIT.ARADDR - BASE_ADDR) >> 4);

  assign head      = q[rptr];
  assign word_base = BASE_ADDR + 32'({head.idx, 4'b0000});

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign lanes[k] = word_base + 32'(4 * k);
  end

  // Empty queue forces zero data, which also covers the reset state.
  assign RIT.RDATA = (RIT.RVALID && !head.err) ? lanes : '0;
  assign RIT.RRESP = (RIT.RVALID && head.err) ? 2'b11 : 2'b00;

  always_ff @(posedge CLK) begin
    if (acc) q[wptr] <= new_req;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (acc) wptr <= inc(wptr);
      if (ret) rptr <= inc(rptr);
      case ({acc, ret})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_leve1_rd_target.sv
// Directed bench for leve1_rd_target: reset, single read, streaming,
// backpressure, address boundaries and reset during traffic.
module tb_leve1_rd_target;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec  = 0;
  int   errs = 0;

  AXI axi();

  leve1_rd_target dut (
    .CLK (clk),
    .RST (rst),
    .RIT (axi)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] exp_word(input logic [31:0] l0);
    return {l0 + 32'd12, l0 + 32'd8, l0 + 32'd4, l0};
  endfunction

  task test_reset;
    axi.ARVALID = 1'b0;
    axi.RREADY  = 1'b0;
    axi.ARADDR  = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vec++;
    if (axi.ARREADY !== 1'b0 || axi.RVALID !== 1'b0 || axi.RRESP !== 2'b00 || axi.RDATA !== '0) begin
      errs++;
      $display("FAIL reset_hold: arready=%b rvalid=%b rresp=%b rdata=%h, expected 0/0/00/0",
               axi.ARREADY, axi.RVALID, axi.RRESP, axi.RDATA);
    end
    rst = 1'b0;
    #1;
    vec++;
    if (axi.ARREADY !== 1'b1 || axi.RVALID !== 1'b0) begin
      errs++;
      $display("FAIL reset_release: arready=%b rvalid=%b, expected arready=1 rvalid=0",
               axi.ARREADY, axi.RVALID);
    end
  endtask

  task test_single;
    @(negedge clk);
    axi.ARADDR  = 32'h8000_0000;
    axi.ARVALID = 1'b1;
    axi.RREADY  = 1'b1;
    vec++;
    if (axi.ARREADY !== 1'b1) begin
      errs++;
      $display("FAIL single_arready: got %b, expected 1", axi.ARREADY);
    end
    @(negedge clk);
    axi.ARVALID = 1'b0;
    vec++;
    if (axi.RVALID !== 1'b1 || axi.RRESP !== 2'b00 ||
        axi.RDATA !== 128'h8000000c_80000008_80000004_80000000) begin
      errs++;
      $display("FAIL single_resp: rvalid=%b rresp=%b rdata=%h, expected 1/00/8000000c800000088000000480000000",
               axi.RVALID, axi.RRESP, axi.RDATA);
    end
    @(negedge clk);
    vec++;
    if (axi.RVALID !== 1'b0) begin
      errs++;
      $display("FAIL single_drain: rvalid=%b, expected 0", axi.RVALID);
    end
  endtask

  task test_stream;
    logic [31:0] l0;
    axi.RREADY = 1'b1;
    for (int j = 0; j <= 16; j++) begin
      @(negedge clk);
      if (j > 0) begin
        l0 = 32'h8000_0000 + 32'(16 * (j - 1));
        vec++;
        if (axi.RVALID !== 1'b1 || axi.RRESP !== 2'b00 || axi.RDATA !== exp_word(l0)) begin
          errs++;
          $display("FAIL stream_beat%0d: rvalid=%b rresp=%b rdata=%h, expected 1/00/%h",
                   j - 1, axi.RVALID, axi.RRESP, axi.RDATA, exp_word(l0));
        end
      end
      if (j < 16) begin
        vec++;
        if (axi.ARREADY !== 1'b1) begin
          errs++;
          $display("FAIL stream_arready%0d: got %b, expected 1", j, axi.ARREADY);
        end
        axi.ARADDR  = 32'h8000_0000 + 32'(16 * j);
        axi.ARVALID = 1'b1;
      end else begin
        axi.ARVALID = 1'b0;
      end
    end
    @(negedge clk);
    vec++;
    if (axi.RVALID !== 1'b0) begin
      errs++;
      $display("FAIL stream_drain: rvalid=%b, expected 0", axi.RVALID);
    end
  endtask

  task test_backpressure;
    logic [31:0] a [6];
    int sent, got;
    for (int i = 0; i < 6; i++) a[i] = 32'h8000_0100 + 32'(16 * i);
    sent = 0;
    got  = 0;
    axi.RREADY = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      vec++;
      if (axi.ARREADY !== (cyc < 4)) begin
        errs++;
        $display("FAIL bp_arready%0d: got %b, expected %b", cyc, axi.ARREADY, (cyc < 4));
      end
      if (cyc > 0) begin
        vec++;
        if (axi.RVALID !== 1'b1 || axi.RRESP !== 2'b00 || axi.RDATA !== exp_word(a[0])) begin
          errs++;
          $display("FAIL bp_hold%0d: rvalid=%b rresp=%b rdata=%h, expected 1/00/%h",
                   cyc, axi.RVALID, axi.RRESP, axi.RDATA, exp_word(a[0]));
        end
      end
      axi.ARADDR  = a[sent];
      axi.ARVALID = 1'b1;
      if (axi.ARREADY) sent++;
    end
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      axi.RREADY = 1'b1;
      if (cyc == 0) begin
        vec++;
        if (axi.ARREADY !== 1'b0) begin
          errs++;
          $display("FAIL bp_full_retire: arready=%b, expected 0", axi.ARREADY);
        end
      end
      if (axi.RVALID) begin
        vec++;
        if (axi.RRESP !== 2'b00 || axi.RDATA !== exp_word(a[got])) begin
          errs++;
          $display("FAIL bp_resp%0d: rresp=%b rdata=%h, expected 00/%h",
                   got, axi.RRESP, axi.RDATA, exp_word(a[got]));
        end
        got++;
      end
      if (sent < 6) begin
        axi.ARADDR  = a[sent];
        axi.ARVALID = 1'b1;
        if (axi.ARREADY) sent++;
      end else begin
        axi.ARVALID = 1'b0;
      end
    end
    axi.ARVALID = 1'b0;
    vec++;
    if (got != 6) begin
      errs++;
      $display("FAIL bp_timeout: got %0d responses, expected 6", got);
    end
    @(negedge clk);
    vec++;
    if (axi.RVALID !== 1'b0) begin
      errs++;
      $display("FAIL bp_drain: rvalid=%b, expected 0", axi.RVALID);
    end
  endtask

  task test_boundary;
    logic [31:0]  addr [6];
    logic [1:0]   resp [6];
    logic [127:0] data [6];
    addr[0] = 32'h8000_3FF0; resp[0] = 2'b00; data[0] = 128'h80003ffc_80003ff8_80003ff4_80003ff0;
    addr[1] = 32'h8000_4000; resp[1] = 2'b11; data[1] = '0;
    addr[2] = 32'h0000_0000; resp[2] = 2'b11; data[2] = '0;
    addr[3] = 32'h8000_0014; resp[3] = 2'b00; data[3] = 128'h8000001c_80000018_80000014_80000010;
    addr[4] = 32'h8000_0010; resp[4] = 2'b00; data[4] = 128'h8000001c_80000018_80000014_80000010;
    addr[5] = 32'h7FFF_FFF0; resp[5] = 2'b11; data[5] = '0;
    axi.RREADY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      axi.ARADDR  = addr[i];
      axi.ARVALID = 1'b1;
      @(negedge clk);
      axi.ARVALID = 1'b0;
      vec++;
      if (axi.RVALID !== 1'b1 || axi.RRESP !== resp[i] || axi.RDATA !== data[i]) begin
        errs++;
        $display("FAIL bound_%h: rvalid=%b rresp=%b rdata=%h, expected 1/%b/%h",
                 addr[i], axi.RVALID, axi.RRESP, axi.RDATA, resp[i], data[i]);
      end
    end
  endtask

  task test_reset_mid;
    axi.RREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      axi.ARADDR  = 32'h8000_0200 + 32'(16 * i);
      axi.ARVALID = 1'b1;
    end
    @(negedge clk);
    axi.ARVALID = 1'b0;
    vec++;
    if (axi.RVALID !== 1'b1) begin
      errs++;
      $display("FAIL rmid_queued: rvalid=%b, expected 1", axi.RVALID);
    end
    #2 rst = 1'b1;
    #1;
    vec++;
    if (axi.RVALID !== 1'b0 || axi.ARREADY !== 1'b0 || axi.RDATA !== '0) begin
      errs++;
      $display("FAIL rmid_async: rvalid=%b arready=%b rdata=%h, expected 0/0/0",
               axi.RVALID, axi.ARREADY, axi.RDATA);
    end
    @(negedge clk);
    rst = 1'b0;
    axi.RREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vec++;
      if (axi.RVALID !== 1'b0) begin
        errs++;
        $display("FAIL rmid_stale%0d: rvalid=%b, expected 0", i, axi.RVALID);
      end
    end
    axi.ARADDR  = 32'h8000_0020;
    axi.ARVALID = 1'b1;
    @(negedge clk);
    axi.ARVALID = 1'b0;
    vec++;
    if (axi.RVALID !== 1'b1 || axi.RDATA[31:0] !== 32'h8000_0020 ||
        axi.RDATA !== 128'h8000002c_80000028_80000024_80000020) begin
      errs++;
      $display("FAIL rmid_newread: rvalid=%b rdata=%h, expected 1/8000002c800000288000002480000020",
               axi.RVALID, axi.RDATA);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_single;
    test_stream;
    test_backpressure;
    test_boundary;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/leve1_rd_target.md
LEVE1_RD_TARGET -- requirements
Module: leve1_rd_target

Interface
REQ-001 Parameter BASE_ADDR, default 32'h8000_0000: byte address of memory word 0.
REQ-002 Parameter DEPTH_LOG2, default 10: memory holds 2**DEPTH_LOG2 words of 128 bits.
REQ-003 Parameter OUTSTANDING, default 4: request queue depth; must be at least 1.
REQ-004 Port CLK, input, 1: sole clock; all state updates on its rising edge.
REQ-005 Port RST, input, 1: asynchronous, active-high reset.
REQ-006 The block SHALL expose the AXI read-channel target modport "AXI.r_targ RIT", containing the ports below.
REQ-007 RIT.ARADDR, input, 32: read byte address.
REQ-008 RIT.ARVALID, input, 1: address valid.
REQ-009 RIT.ARREADY, output, 1: address accepted this cycle when high together with ARVALID.
REQ-010 RIT.RDATA, output, 128: read data.
REQ-011 RIT.RRESP, output, 2: 2'b00 OKAY, 2'b11 DECERR.
REQ-012 RIT.RVALID, output, 1: response valid.
REQ-013 RIT.RREADY, input, 1: response accepted this cycle when high together with RVALID.

Function
REQ-014 Memory content SHALL be fixed at elaboration.
  - 32-bit lane k (k=0..3, lane 0 = bits 31:0) of word i holds BASE_ADDR + 16*i + 4*k, modulo 2**32.
  - The block is read-only.
REQ-015 A request SHALL be accepted on a cycle where ARVALID && ARREADY.
REQ-016 ARREADY SHALL equal !full.
  - full means the number of accepted-but-unretired requests equals OUTSTANDING.
  - ARREADY is driven from registered state only; it has no combinational path from ARVALID or RREADY.
REQ-017 ARADDR[3:0] SHALL be ignored; the word index is (ARADDR - BASE_ADDR) >> 4.
REQ-018 Address range check:
  - A request is in range when BASE_ADDR <= ARADDR < BASE_ADDR + 16*2**DEPTH_LOG2, using 33-bit unsigned comparison with no wrap-around.
  - In range: response is RRESP=00 with the word data.
  - Out of range: response is RRESP=11 with RDATA=0.
REQ-019 Latency: a request accepted in cycle n with an empty pipeline SHALL present RVALID=1 in cycle n+1.
REQ-020 With ARVALID and RREADY held high, the block SHALL sustain one accepted request and one retired response per cycle.
REQ-021 Responses SHALL be returned in acceptance order, exactly one response per accepted request.
REQ-022 A request retires when RVALID && RREADY.
REQ-023 While RVALID && !RREADY, RDATA, RRESP and RVALID SHALL hold stable.
REQ-024 RVALID SHALL never deassert without a handshake, except on reset.
REQ-025 Accept and retire in the same cycle SHALL leave the occupancy count unchanged.
  - When full, ARREADY stays 0 in the retire cycle; new acceptance resumes the following cycle.
REQ-026 The queue read and write pointers SHALL wrap modulo OUTSTANDING, with no loss or duplication at wrap.
REQ-027 RVALID SHALL be 0 whenever the queue is empty.

Reset
REQ-028 While RST=1, the block SHALL drive ARREADY=0, RVALID=0, RRESP=00 and RDATA=0.
  - These values take effect asynchronously on assertion of RST.
REQ-029 Assertion of RST SHALL discard all queued and in-flight requests; no response is issued for them after reset.
REQ-030 In the first CLK edge after RST deasserts, the block SHALL present ARREADY=1 with the queue empty.

Verification
REQ-031 Single read: after reset, ARADDR=32'h8000_0000 is accepted in cycle n with RREADY=1 -> in cycle n+1, RVALID=1, RRESP=00 and RDATA=128'h8000000c_80000008_80000004_80000000.
REQ-032 Streaming: ARVALID is held at 1, ARADDR starts at 0x8000_0000 and steps by 0x10 per accept, RREADY=1, for 16 requests -> 16 consecutive responses one per cycle, in order; beat j has lane 0 = 0x8000_0000 + 16*j.
REQ-033 Backpressure: RREADY=0 and 6 requests are offered -> 4 are accepted, then ARREADY=0; the first response is held stable. RREADY is then raised -> 4 responses retire in order, and the remaining 2 requests are accepted and answered.
REQ-034 Boundaries:
  - ARADDR=0x8000_3FF0 -> RRESP=00, lane 0 = 0x8000_3FF0.
  - ARADDR=0x8000_4000 and ARADDR=0x0000_0000 -> RRESP=11, RDATA=0.
  - ARADDR=0x8000_0014 -> same data as 0x8000_0010.
REQ-035 Reset mid-operation: 3 requests are queued with RREADY=0, then RST is pulsed -> RVALID and ARREADY drop to 0 asynchronously, and no stale response appears after reset. A new read of 0x8000_0020 then returns lane 0 = 0x8000_0020.
